// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle between the timing generator and pixel consumers.
// The generator takes the master side: it receives pix_ce and drives the raster outputs.
interface vga_timing_gen_if;
  logic       pix_ce;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic [9:0] frame;

  modport master (
    input  pix_ce,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame
  );

  modport slave (
    output pix_ce,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, sync pulses,
// display-enable window, frame counter and line/frame strobes.
// Every output is a register, updated from next-state values so all of them
// describe the same pixel in any given cycle.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input logic clk,
  input logic reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be in 1..1024");
  end

  // Boundaries kept 11 bits wide so a sync end of exactly 1024 does not alias to 0.
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS   = 11'(H_DISPLAY);
  localparam logic [10:0] H_SS    = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SE    = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS   = 11'(V_DISPLAY);
  localparam logic [10:0] V_SS    = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SE    = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0]  r_hpos;
  logic [9:0]  r_vpos;
  logic [9:0]  r_frame;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_display_on;
  logic        r_line_start;
  logic        r_frame_start;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [9:0]  w_hpos_nxt;
  logic [9:0]  w_vpos_nxt;
  logic [9:0]  w_frame_nxt;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;

  // Next raster position and frame count for an advancing pixel.
  always_comb begin
    w_h_wrap    = (r_hpos == H_LAST);
    w_v_wrap    = (r_vpos == V_LAST);
    w_hpos_nxt  = w_h_wrap ? '0 : r_hpos + 10'd1;
    w_vpos_nxt  = r_vpos;
    if (w_h_wrap) begin
      w_vpos_nxt = w_v_wrap ? '0 : r_vpos + 10'd1;
    end
    w_frame_nxt = (w_h_wrap && w_v_wrap) ? r_frame + 10'd1 : r_frame;
    w_h_ext     = {1'b0, w_hpos_nxt};
    w_v_ext     = {1'b0, w_vpos_nxt};
  end

  // Counters and level outputs advance on pix_ce; strobes mark landing on a line/frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_frame       <= '0;
      r_display_on  <= 1'b1;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (bus.pix_ce) begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_frame       <= w_frame_nxt;
      r_display_on  <= (w_h_ext < H_VIS) && (w_v_ext < V_VIS);
      r_hsync       <= ((w_h_ext >= H_SS) && (w_h_ext < H_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync       <= ((w_v_ext >= V_SS) && (w_v_ext < V_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.hpos        = r_hpos;
  assign bus.vpos        = r_vpos;
  assign bus.frame       = r_frame;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.display_on  = r_display_on;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule
